// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Sequencer for a 2-to-4 decoder. It steps a 2-bit select index through the
//   enabled channels, holding each one for DWELL_CYCLES clocks. The scan can
//   free-run, or it can hold and advance one channel at a time on `step`.
//
//   Optional feature (macro SCAN_BLANK_EN): every advance that changes `sel`
//   adds one BLANK cycle with sel_valid=0. This gives dead time for
//   multiplexed displays.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   run        1 = free-running scan, 0 = hold and advance on step
//   step       single-cycle advance request, used only when run=0
//   dir        0 = ascending index, 1 = descending index
//   ch_mask    channel enable mask, bit i enables index i
//   sel        current channel index (registered)
//   sel_valid  sel is active and the decoder output may be used (registered)
//   adv        one-cycle pulse in the cycle sel takes a new value (registered)
module decoder_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       dir,
  input  logic [3:0] ch_mask,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       adv
);

  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Returns the first enabled index after `start`, walking in `dir` order.
  // The search wraps and tries `start` itself last. The candidates are
  // visited from the farthest to the nearest, so the nearest hit is the one
  // that remains.
  function automatic logic [1:0] search(input logic [1:0] start,
                                        input logic [3:0] m,
                                        input logic       d);
    logic [1:0] idx;
    search = start;
    for (int k = 4; k >= 1; k--) begin
      idx = d ? start - 2'(k) : start + 2'(k);
      if (m[idx]) search = idx;
    end
  endfunction

  logic [1:0] first_ch, nxt_ch;
  logic       do_adv;

  // Ascending from 3 reaches the lowest set bit first.
  // Descending from 0 reaches the highest set bit first.
  assign first_ch = search(dir ? 2'd0 : 2'd3, ch_mask, dir);
  assign nxt_ch   = search(sel, ch_mask, dir);

  // Losing the current channel forces an advance. Otherwise the counter
  // expiry (run=1) or step (run=0) starts the advance.
  assign do_adv = !ch_mask[sel] || (run ? (cnt == CNT_LAST) : step);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      sel_valid <= 1'b0;
      adv       <= 1'b0;
      cnt       <= '0;
    end else begin
      adv <= 1'b0;
      case (state)
        IDLE: begin
          sel_valid <= 1'b0;
          if (ch_mask != 4'd0) begin
            sel       <= first_ch;
            sel_valid <= 1'b1;
            adv       <= 1'b1;
            cnt       <= '0;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (ch_mask == 4'd0) begin
            state     <= IDLE;
            sel_valid <= 1'b0;
          end else if (do_adv) begin
            sel <= nxt_ch;
            cnt <= '0;
            adv <= (nxt_ch != sel);
`ifdef SCAN_BLANK_EN
            if (nxt_ch != sel) begin
              state     <= BLANK;
              sel_valid <= 1'b0;
            end
`endif
          end else if (run) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (ch_mask == 4'd0) begin
            state <= IDLE;
          end else begin
            state     <= DWELL;
            sel_valid <= 1'b1;
            cnt       <= '0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          sel_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  localparam int D = 4;
`ifdef SCAN_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, run, step, dir;
  logic [3:0] ch_mask;
  logic [1:0] sel;
  logic       sel_valid, adv;

  int checks = 0;
  int errors = 0;

  decoder_scan_ctrl #(.DWELL_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .dir(dir),
    .ch_mask(ch_mask), .sel(sel), .sel_valid(sel_valid), .adv(adv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. It tracks whether the scan is active, the selected
  // channel, the cycles spent on that channel, and whether a blank cycle is
  // in progress.
  bit         m_on, m_blank, m_valid, m_adv;
  logic [1:0] m_sel;
  int         m_el;

  always begin
    @(posedge clk);
    if (rst) begin
      m_on = 0; m_blank = 0; m_valid = 0; m_adv = 0; m_sel = 0; m_el = 0;
    end else if (!m_on) begin
      m_adv = 0; m_valid = 0;
      if (ch_mask != 0) begin
        // Lowest enabled bit for ascending, highest for descending.
        for (int i = 0; i < 4; i++)
          if (ch_mask[dir ? 3 - i : i] && !m_adv) begin
            m_sel = 2'(dir ? 3 - i : i);
            m_adv = 1;
          end
        m_on = 1; m_valid = 1; m_el = 0;
      end
    end else if (ch_mask == 0) begin
      m_on = 0; m_blank = 0; m_valid = 0; m_adv = 0;
    end else if (m_blank) begin
      m_blank = 0; m_valid = 1; m_adv = 0; m_el = 0;
    end else if (!ch_mask[m_sel] || (run && m_el == D - 1) || (!run && step)) begin
      int ns;
      ns = m_sel;
      for (int k = 3; k >= 1; k--)
        if (ch_mask[(m_sel + (dir ? 4 - k : k)) % 4]) ns = (m_sel + (dir ? 4 - k : k)) % 4;
      m_adv   = (ns != m_sel);
      m_sel   = 2'(ns);
      m_el    = 0;
      m_blank = BLK && m_adv;
      m_valid = !m_blank;
    end else begin
      m_adv = 0;
      if (run) m_el++;
    end
    #1;
    chk("model_sel", 8'(sel), 8'(m_sel));
    chk("model_valid", 8'(sel_valid), 8'(m_valid));
    chk("model_adv", 8'(adv), 8'(m_adv));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic lit(input string name, input logic [1:0] s, input logic v, input logic a);
`ifndef SCAN_BLANK_EN
    chk({name, "_sel"}, 8'(sel), 8'(s));
    chk({name, "_valid"}, 8'(sel_valid), 8'(v));
    chk({name, "_adv"}, 8'(adv), 8'(a));
`endif
  endtask

  task automatic lit_blk(input string name, input logic [1:0] s, input logic v, input logic a);
`ifdef SCAN_BLANK_EN
    chk({name, "_sel"}, 8'(sel), 8'(s));
    chk({name, "_valid"}, 8'(sel_valid), 8'(v));
    chk({name, "_adv"}, 8'(adv), 8'(a));
`endif
  endtask

  initial begin
    rst = 1; run = 0; step = 0; dir = 0; ch_mask = 4'b0000;
    tick(2);
`ifndef SCAN_BLANK_EN
    chk("reset_sel", 8'(sel), 8'd0);
    chk("reset_valid", 8'(sel_valid), 8'd0);
    chk("reset_adv", 8'(adv), 8'd0);
`endif
    // 1: full mask, ascending free run
    rst = 0; ch_mask = 4'b1111; run = 1;
    tick(1); lit("t1_entry", 0, 1, 1);
    tick(4); lit("t1_s1", 1, 1, 1);
    tick(4); lit("t1_s2", 2, 1, 1);
    tick(4); lit("t1_s3", 3, 1, 1);
    tick(4); lit("t1_wrap", 0, 1, 1);
    // 2: mask 1010 descending, then dir flip mid-dwell
    ch_mask = 4'b1010; dir = 1;
    tick(1); lit("t2_forced", 3, 1, 1);
    tick(4); lit("t2_s1", 1, 1, 1);
    tick(2); dir = 0;
    tick(2); lit("t2_asc3", 3, 1, 1);
    tick(4); lit("t2_wrap1", 1, 1, 1);
    // 3: hold and step
    ch_mask = 4'b1111; run = 0;
    tick(20); lit("t3_hold", 1, 1, 0);
    step = 1;
    tick(1); lit("t3_step", 2, 1, 1);
    step = 1; run = 1;
    tick(1); lit("t3_step_ign", 2, 1, 0);
    step = 0;
    // 4: single channel, zero mask, re-entry
    ch_mask = 4'b0000;
    tick(1); lit("t4_idle", 2, 0, 0);
    ch_mask = 4'b0100;
    tick(1); lit("t4_entry", 2, 1, 1);
    for (int i = 0; i < 12; i++) begin
      tick(1); lit("t4_noadv", 2, 1, 0);
    end
    ch_mask = 4'b0000;
    tick(1); lit("t4_zero", 2, 0, 0);
    ch_mask = 4'b0001;
    tick(1); lit("t4_reentry", 0, 1, 1);
    // 5: forced advance, then reset mid-dwell
    ch_mask = 4'b1111;
    tick(4); lit("t5_s1", 1, 1, 1);
    tick(2); ch_mask = 4'b1101;
    tick(1); lit("t5_forced", 2, 1, 1);
    tick(3); lit("t5_cnt0", 2, 1, 0);
    tick(1); lit("t5_next", 3, 1, 1);
    tick(1); rst = 1;
    tick(1); lit("t5_rst", 0, 0, 0);
    tick(1);
    // 6: blanking behaviour (literal pins only in the blank build)
    rst = 0; ch_mask = 4'b1111; dir = 0; run = 1;
    tick(1); lit_blk("t6_entry", 0, 1, 1);
    tick(4); lit_blk("t6_blank1", 1, 0, 1);
    tick(1); lit_blk("t6_dwell1", 1, 1, 0);
    tick(4); lit_blk("t6_blank2", 2, 0, 1);
    ch_mask = 4'b0000;
    tick(1); lit_blk("t6_idle", 2, 0, 0);
    tick(2); lit_blk("t6_idle2", 2, 0, 0);
    ch_mask = 4'b0010; dir = 1;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
